aes_round_stage: RTL and testbench

- Registered round back-end of the AES-256-GCM core; sits directly downstream of the SubBytes stage and consumes its 128-bit output.
- Applies ShiftRows, then MixColumns (skipped when the round is flagged last), then AddRoundKey with the supplied round key.
- Wraps the datapath in a valid/ready pipeline stage with a 2-entry skid buffer, so back-pressure never drops or duplicates a round.

---
 rtl/aes_round_stage.sv | 167 ++++++++++++++++
 tb/tb_aes_round_stage.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_round_stage.sv
`default_nettype none
// ============================================================================
//  Module   : aes_round_stage
//  Purpose  : Registered AES round back-end. Takes the SubBytes output and
//             applies ShiftRows, MixColumns (bypassed on the last round) and
//             AddRoundKey. The datapath sits behind a valid/ready stage with
//             a 2-entry skid buffer, so back-pressure never loses or repeats
//             a round.
//  Ports    : clk, rst_n              clock / synchronous active-low reset
//             in_valid/in_ready       upstream handshake
//             in_state, in_rkey       128-bit state and round key, column-major
//             in_last, in_tag         final-round flag and opaque sideband
//             out_valid/out_ready     downstream handshake
//             out_state, out_last,    registered round result and the
//             out_tag                 sideband that travels with it
//  Revision : 1.0  initial release
// ============================================================================
module aes_round_stage #(
   parameter int TAG_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [127:0]     in_state,
   input  logic [127:0]     in_rkey,
   input  logic             in_last,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [127:0]     out_state,
   output logic             out_last,
   output logic [TAG_W-1:0] out_tag
);

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_TWO   = 2'd2
   } state_e;

   state_e             state_q, state_d;
   logic [127:0]       m_state_q, s_state_q;
   logic               m_last_q,  s_last_q;
   logic [TAG_W-1:0]   m_tag_q,   s_tag_q;

   logic               accept, pop;
   logic               load_m, load_s, m_from_s;
   logic [127:0]       round_res;
   logic [7:0]         sr [4][4];
   logic [7:0]         mc [4][4];

   // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   // ------------------------------------------------------------------
   // Round datapath. Byte k = 4*col+row lives at bits [127-8k -: 8].
   // ------------------------------------------------------------------
   always_comb begin
      round_res = '0;
      // ShiftRows: row r rotated left by r columns.
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            sr[r][c] = in_state[127 - 8*(4*((c + r) % 4) + r) -: 8];
         end
      end
      // MixColumns: out[r] = 2*a[r] ^ 3*a[r+1] ^ a[r+2] ^ a[r+3] (indices mod 4).
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            mc[r][c] = xtime(sr[r][c]) ^ xtime(sr[(r + 1) % 4][c]) ^ sr[(r + 1) % 4][c]
                     ^ sr[(r + 2) % 4][c] ^ sr[(r + 3) % 4][c];
         end
      end
      // AddRoundKey.
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            round_res[127 - 8*(4*c + r) -: 8] = (in_last ? sr[r][c] : mc[r][c])
                                              ^ in_rkey[127 - 8*(4*c + r) -: 8];
         end
      end
   end

   // ------------------------------------------------------------------
   // Handshake control. in_ready depends on registered state only.
   // ------------------------------------------------------------------
   assign in_ready  = (state_q != ST_TWO);
   assign out_valid = (state_q != ST_EMPTY);
   assign accept    = in_valid && in_ready;
   assign pop       = out_valid && out_ready;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_EMPTY;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      load_m   = 1'b0;
      load_s   = 1'b0;
      m_from_s = 1'b0;
      case (state_q)
         ST_EMPTY: begin
            if (accept) begin
               load_m  = 1'b1;
               state_d = ST_ONE;
            end
         end
         ST_ONE: begin
            if (pop && accept) begin
               load_m = 1'b1;            // streaming: replace the beat just leaving
            end else if (pop) begin
               state_d = ST_EMPTY;       // M keeps its stale contents
            end else if (accept) begin
               load_s  = 1'b1;           // downstream stalled: park in the skid entry
               state_d = ST_TWO;
            end
         end
         ST_TWO: begin
            if (pop) begin
               m_from_s = 1'b1;
               state_d  = ST_ONE;
            end
         end
         default: state_d = ST_EMPTY;
      endcase
   end

   // ------------------------------------------------------------------
   // Main (M) and skid (S) data registers.
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         m_state_q <= '0;
         m_last_q  <= 1'b0;
         m_tag_q   <= '0;
         s_state_q <= '0;
         s_last_q  <= 1'b0;
         s_tag_q   <= '0;
      end else begin
         if (load_m) begin
            m_state_q <= round_res;
            m_last_q  <= in_last;
            m_tag_q   <= in_tag;
         end else if (m_from_s) begin
            m_state_q <= s_state_q;
            m_last_q  <= s_last_q;
            m_tag_q   <= s_tag_q;
         end
         if (load_s) begin
            s_state_q <= round_res;
            s_last_q  <= in_last;
            s_tag_q   <= in_tag;
         end
      end
   end

   assign out_state = m_state_q;
   assign out_last  = m_last_q;
   assign out_tag   = m_tag_q;

endmodule
`default_nettype wire

// File: tb/tb_aes_round_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_aes_round_stage
//  Purpose  : Self-checking bench for aes_round_stage. Accepted beats push
//             the reference result into a queue; every valid output cycle is
//             compared with the queue head, which is popped on handshake.
//  Revision : 1.0  initial release
// ============================================================================
module tb_aes_round_stage;

   localparam int TAG_W = 4;
   localparam int W     = 129 + TAG_W;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             in_valid;
   logic             in_ready;
   logic [127:0]     in_state;
   logic [127:0]     in_rkey;
   logic             in_last;
   logic [TAG_W-1:0] in_tag;
   logic             out_valid;
   logic             out_ready;
   logic [127:0]     out_state;
   logic             out_last;
   logic [TAG_W-1:0] out_tag;

   int n_checks = 0;
   int n_errors = 0;
   logic [W-1:0] sb_q[$];
   bit rand_mode  = 1'b0;
   bit stream_chk = 1'b0;

   aes_round_stage #(.TAG_W(TAG_W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_state  (in_state),
      .in_rkey   (in_rkey),
      .in_last   (in_last),
      .in_tag    (in_tag),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_state (out_state),
      .out_last  (out_last),
      .out_tag   (out_tag)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      logic [7:0] x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      end
      return p;
   endfunction

   function automatic logic [127:0] ref_round(input logic [127:0] st, input logic [127:0] key,
                                              input logic last);
      logic [7:0] s [4][4];
      logic [7:0] t [4][4];
      logic [7:0] m [4][4];
      logic [127:0] res;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            s[r][c] = st[127 - 8*(4*c + r) -: 8];
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            t[r][c] = s[r][(c + r) % 4];
      for (int c = 0; c < 4; c++) begin
         m[0][c] = gmul(t[0][c], 8'h02) ^ gmul(t[1][c], 8'h03) ^ t[2][c] ^ t[3][c];
         m[1][c] = t[0][c] ^ gmul(t[1][c], 8'h02) ^ gmul(t[2][c], 8'h03) ^ t[3][c];
         m[2][c] = t[0][c] ^ t[1][c] ^ gmul(t[2][c], 8'h02) ^ gmul(t[3][c], 8'h03);
         m[3][c] = gmul(t[0][c], 8'h03) ^ t[1][c] ^ t[2][c] ^ gmul(t[3][c], 8'h02);
      end
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            res[127 - 8*(4*c + r) -: 8] = (last ? t[r][c] : m[r][c]) ^ key[127 - 8*(4*c + r) -: 8];
      return res;
   endfunction

   // ---------------- scoreboard monitor (samples on falling edge) ----------------
   always @(negedge clk) begin
      if (!rst_n) begin
         sb_q.delete();
      end else begin
         if (stream_chk) check("stream_in_ready", W'(in_ready), W'(1));
         if (out_valid) begin
            if (sb_q.size() == 0) begin
               check("spurious_out_valid", W'(out_valid), W'(0));
            end else begin
               check("out_beat", {out_state, out_last, out_tag}, sb_q[0]);
               if (out_ready) void'(sb_q.pop_front());
            end
         end
         if (in_valid && in_ready)
            sb_q.push_back({ref_round(in_state, in_rkey, in_last), in_last, in_tag});
      end
   end

   // Random back-pressure, applied just after each rising edge.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (rand_mode) out_ready = 1'($urandom_range(0, 1));
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   // Callers are positioned just after a rising edge; returns likewise, beat accepted.
   task automatic send(input logic [127:0] st, input logic [127:0] key, input logic last,
                       input logic [TAG_W-1:0] tag);
      int  n    = 0;
      bit  done = 1'b0;
      in_valid = 1'b1;
      in_state = st;
      in_rkey  = key;
      in_last  = last;
      in_tag   = tag;
      while (!done) begin
         @(negedge clk);
         if (in_ready) done = 1'b1;
         else if (++n > 500) begin
            check("accept_timeout", W'(0), W'(1));
            done = 1'b1;
         end
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while ((sb_q.size() != 0 || out_valid) && n < 400) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("drain_timeout", W'(n < 400), W'(1));
   endtask

   task automatic idle();
      @(posedge clk);
      #1;
   endtask

   localparam logic [127:0] T1_ST  = 128'hd42711aee0bf98f1b8b45de51e415230;
   localparam logic [127:0] T1_KEY = 128'ha0fafe1788542cb123a339392a6c7605;
   localparam logic [127:0] T1_EXP = 128'ha49c7ff2689f352b6b5bea43026a5049;
   localparam logic [127:0] T2_ST  = 128'he9098972cb31075f3d327d94af2e2cb5;
   localparam logic [127:0] T2_KEY = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
   localparam logic [127:0] T2_EXP = 128'h3925841d02dc09fbdc118597196a0b32;

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_state  = '0;
      in_rkey   = '0;
      in_last   = 1'b0;
      in_tag    = '0;
      out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Reset state
      @(negedge clk);
      check("rst_out_valid", W'(out_valid), W'(0));
      check("rst_in_ready",  W'(in_ready),  W'(1));
      check("rst_out_beat",  {out_state, out_last, out_tag}, W'(0));
      idle();

      // 1. Middle round, 1-cycle latency
      send(T1_ST, T1_KEY, 1'b0, 4'd1);
      @(negedge clk);
      check("t1_out_valid", W'(out_valid), W'(1));
      check("t1_out_beat",  {out_state, out_last, out_tag}, {T1_EXP, 1'b0, 4'd1});
      idle();

      // 2. Final round
      send(T2_ST, T2_KEY, 1'b1, 4'd2);
      @(negedge clk);
      check("t2_out_beat", {out_state, out_last, out_tag}, {T2_EXP, 1'b1, 4'd2});
      idle();
      drain();

      // 3. Back-pressure: two beats fill the stage, the third stalls
      out_ready = 1'b0;
      send({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom}, 1'b0, 4'd1);
      send({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom}, 1'b1, 4'd2);
      in_valid = 1'b1;
      in_tag   = 4'd3;
      repeat (3) begin
         @(negedge clk);
         check("bp_in_ready", W'(in_ready), W'(0));
         check("bp_held_tag", W'(out_tag), W'(1));
      end
      idle();
      out_ready = 1'b1;
      send({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom}, 1'b0, 4'd3);
      drain();

      // 4. Streaming: 16 back-to-back beats, in_ready must stay high
      stream_chk = 1'b1;
      for (int i = 0; i < 16; i++)
         send({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom},
              1'($urandom_range(0, 1)), 4'(i));
      stream_chk = 1'b0;
      drain();

      // 5. Random back-pressure over 1000 beats
      rand_mode = 1'b1;
      for (int i = 0; i < 1000; i++) begin
         if ($urandom_range(0, 7) == 0) idle();
         send({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom},
              1'($urandom_range(0, 1)), 4'($urandom));
      end
      rand_mode = 1'b0;
      idle();
      out_ready = 1'b1;
      drain();

      // 6. Reset while holding two beats
      out_ready = 1'b0;
      send({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom}, 1'b0, 4'd7);
      send({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom}, 1'b1, 4'd8);
      @(negedge clk);
      check("two_in_ready", W'(in_ready), W'(0));
      idle();
      rst_n = 1'b0;
      idle();
      rst_n = 1'b1;
      out_ready = 1'b1;
      @(negedge clk);
      check("mid_rst_out_valid", W'(out_valid), W'(0));
      check("mid_rst_out_state", W'(out_state), W'(0));
      check("mid_rst_in_ready",  W'(in_ready),  W'(1));
      idle();
      send(T1_ST, T1_KEY, 1'b0, 4'd1);
      @(negedge clk);
      check("post_rst_out_valid", W'(out_valid), W'(1));
      check("post_rst_out_beat",  {out_state, out_last, out_tag}, {T1_EXP, 1'b0, 4'd1});
      idle();
      drain();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
